// File: rtl/des_pkg.sv
// Shared definitions for the DES byte framer and its neighbours.
package des_pkg;

    // Bit 63 of a block corresponds to DES bit 1 (DES numbers bits MSB-first).
    localparam int DES_BLOCK_W     = 64;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_BLOCK = 8;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } framer_state_t;

endpackage

// File: rtl/des_byte_framer_if.sv
// Byte-stream bundle around the framer: plaintext bytes in, ciphertext bytes out.
// master = the surrounding system (source of plaintext, sink of ciphertext);
// slave  = the framer itself.
interface des_byte_framer_if;
    import des_pkg::*;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

endinterface

// File: rtl/des_byte_framer.sv
// Packs 8 plaintext bytes into a block for the DES core, waits CORE_LAT
// cycles for the core to settle, captures the ciphertext and serialises it
// back out as 8 bytes. Optional CBC chaining against the previous ciphertext
// or a loaded IV. Single-block buffer: filling and draining never overlap.
module des_byte_framer
    import des_pkg::*;
#(
    parameter int CORE_LAT = 1  // legal range 1..15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    des_byte_framer_if.slave       bus,
    input  logic                   cbc_en,
    input  logic                   iv_load,
    input  logic [DES_BLOCK_W-1:0] iv,
    output logic [DES_BLOCK_W-1:0] core_pt,
    input  logic [DES_BLOCK_W-1:0] core_ct,
    output logic                   busy
);

    localparam logic [3:0] WAIT_INIT = 4'(CORE_LAT);
    localparam logic [2:0] LAST_IDX  = 3'(BYTES_PER_BLOCK - 1);
    localparam int         PACK_W    = DES_BLOCK_W - BYTE_W;

    framer_state_t          state_q, state_d;
    logic [2:0]             byte_cnt_q;
    logic [3:0]             wait_cnt_q;
    // Only the first seven bytes need storing; the eighth comes straight
    // from in_data on the edge that completes the block.
    logic [PACK_W-1:0]      pack_reg;
    logic [DES_BLOCK_W-1:0] ct_shift;
    logic [DES_BLOCK_W-1:0] chain;

    logic                   in_fire;
    logic                   out_fire;
    logic                   byte_last;
    logic [DES_BLOCK_W-1:0] packed_blk;

    assign in_fire    = bus.in_valid && bus.in_ready;
    assign out_fire   = bus.out_valid && bus.out_ready;
    assign byte_last  = (byte_cnt_q == LAST_IDX);
    assign packed_blk = {pack_reg, bus.in_data};

    assign bus.out_data = ct_shift[DES_BLOCK_W-1 -: BYTE_W];
    assign busy         = (state_q != FILL) || (byte_cnt_q != '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        unique case (state_q)
            FILL: begin
                bus.in_ready = 1'b1;
                if (in_fire && byte_last) state_d = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == 4'd1) state_d = DRAIN;
            end
            DRAIN: begin
                bus.out_valid = 1'b1;
                bus.out_last  = byte_last;
                if (out_fire && byte_last) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // Datapath: byte packing, core handoff, ciphertext capture/shift, chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            wait_cnt_q <= '0;
            pack_reg   <= '0;
            core_pt    <= '0;
            ct_shift   <= '0;
            chain      <= '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    // IV only lands between blocks; it applies to the block
                    // whose first byte may arrive on this same edge.
                    if (iv_load && byte_cnt_q == '0) chain <= iv;
                    if (in_fire) begin
                        if (byte_last) begin
                            core_pt    <= packed_blk ^ (cbc_en ? chain : '0);
                            wait_cnt_q <= WAIT_INIT;
                            byte_cnt_q <= '0;
                        end else begin
                            pack_reg   <= packed_blk[PACK_W-1:0];
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt_q <= wait_cnt_q - 4'd1;
                    // Chain tracks the ciphertext in ECB mode too, so CBC
                    // can be switched on at any block boundary.
                    if (wait_cnt_q == 4'd1) begin
                        ct_shift <= core_ct;
                        chain    <= core_ct;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        ct_shift   <= {ct_shift[DES_BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                        byte_cnt_q <= byte_last ? '0 : byte_cnt_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
